// File: rtl/mac_pkg.sv
// Shared definitions for the MAC and its operand sequencer: default operand and
// accumulator widths, plus the sequencer state encoding.
package mac_pkg;

    localparam int MAC_DW = 8;
    localparam int MAC_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Operand sequencer that streams element pairs into an external MAC (y = a*b + c),
// chaining each result back into c to form bias + sum(a[i]*b[i]).
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int DW      = MAC_DW,
    parameter int AW      = MAC_AW,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [AW-1:0]    bias,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic [AW-1:0]    mac_c,
    input  logic [AW-1:0]    mac_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [AW-1:0]    res_data,
    output logic             busy
);

    localparam int WCW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    mac_a_q, mac_a_d;
    logic [DW-1:0]    mac_b_q, mac_b_d;
    logic [AW-1:0]    mac_c_q, mac_c_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    res_data_q, res_data_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_c_d     = mac_c_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = bias;
                    remaining_d = len;
                    if (len == '0) begin
                        res_data_d = bias;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (in_valid && in_ready_q) begin
                    mac_a_d    = in_a;
                    mac_b_d    = in_b;
                    mac_c_d    = acc_q;
                    wait_cnt_d = WCW'(MAC_LAT);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches zero after MAC_LAT edges, so mac_y is taken on edge MAC_LAT+1
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end else begin
                    acc_d       = mac_y;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        res_data_d = mac_y;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready && res_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            remaining_d = '0;
            wait_cnt_d  = '0;
        end

        // Handshake outputs are registered, so they are derived from the next state
        in_ready_d  = (state_d == ST_FETCH);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_c_q     <= mac_c_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_c     = mac_c_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a one-stage registered MAC beside it;
// expected values are hand-computed dot products.
module tb_mac_dot_seq;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    bias;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic [AW-1:0]    mac_c;
    logic [AW-1:0]    mac_y;
    logic             res_valid;
    logic             res_ready;
    logic [AW-1:0]    res_data;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int lastLat = 0;

    mac_dot_seq #(
        .DW(DW), .AW(AW), .LEN_W(LEN_W), .MAC_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_y(mac_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    // Single-register MAC model standing in for the external MAC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac_y <= '0;
        else        mac_y <= AW'(mac_a * mac_b) + mac_c;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [LEN_W-1:0] l, input logic [AW-1:0] b);
        start = 1'b1;
        len   = l;
        bias  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic sendElem(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "_mac_a"}, 32'(mac_a), 32'(a));
        checkOutput({tag, "_mac_b"}, 32'(mac_b), 32'(b));
    endtask

    task automatic waitResult(input string tag, input logic [AW-1:0] expected, input int holdCycles);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        lastLat = n;
        checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
        end
        checkOutput({tag, "_data"}, 32'(res_data), 32'(expected));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_mac_c", 32'(mac_c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic: 5 + 3*4 + 10*2 = 37
        applyStimulus(8'd2, 16'd5);
        checkOutput("basic_busy", 32'(busy), 32'd1);
        sendElem("basic_e1", 8'd3, 8'd4);
        checkOutput("basic_c1", 32'(mac_c), 32'd5);
        checkOutput("basic_ready_drop", 32'(in_ready), 32'd0);
        sendElem("basic_e2", 8'd10, 8'd2);
        checkOutput("basic_c2", 32'(mac_c), 32'd17);
        waitResult("basic", 16'd37, 0);
        checkOutput("basic_latency", 32'(lastLat), 32'd2);

        // Zero length returns the bias on the next cycle
        applyStimulus(8'd0, 16'd9);
        checkOutput("zero_valid", 32'(res_valid), 32'd1);
        checkOutput("zero_in_ready", 32'(in_ready), 32'd0);
        waitResult("zero", 16'd9, 0);

        // Wrap: 0xFFFF + 255*255 = 0x1FE00 -> 0xFE00
        applyStimulus(8'd1, 16'hFFFF);
        sendElem("wrap_e1", 8'd255, 8'd255);
        waitResult("wrap", 16'hFE00, 0);

        // Gaps and back-pressure: 1*2 + 3*4 + 5*6 = 44
        applyStimulus(8'd3, 16'd0);
        sendElem("gap_e1", 8'd1, 8'd2);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("gap_stall_ready", 32'(in_ready), 32'd1);
        checkOutput("gap_stall_mac_a", 32'(mac_a), 32'd1);
        sendElem("gap_e2", 8'd3, 8'd4);
        checkOutput("gap_c2", 32'(mac_c), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        sendElem("gap_e3", 8'd5, 8'd6);
        checkOutput("gap_c3", 32'(mac_c), 32'd14);
        waitResult("gap", 16'd44, 5);
        checkOutput("gap_no_extra_issue", 32'(mac_a), 32'd5);

        // Abort in WAIT of element 2 of 4, then a fresh 2*3
        applyStimulus(8'd4, 16'd0);
        sendElem("abort_e1", 8'd1, 8'd1);
        sendElem("abort_e2", 8'd2, 8'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
        tick();
        tick();
        checkOutput("abort_stays_idle", 32'(res_valid), 32'd0);
        applyStimulus(8'd1, 16'd0);
        sendElem("post_abort_e1", 8'd2, 8'd3);
        checkOutput("post_abort_c", 32'(mac_c), 32'd0);
        waitResult("post_abort", 16'd6, 0);

        // Asynchronous reset while waiting in FETCH for element 2
        applyStimulus(8'd2, 16'd5);
        sendElem("rstmid_e1", 8'd3, 8'd4);
        for (int i = 0; i < 3 && !in_ready; i++) tick();
        checkOutput("rstmid_in_fetch", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_mac_a", 32'(mac_a), 32'd0);
        checkOutput("rstmid_mac_b", 32'(mac_b), 32'd0);
        checkOutput("rstmid_mac_c", 32'(mac_c), 32'd0);
        checkOutput("rstmid_res_data", 32'(res_data), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        applyStimulus(8'd2, 16'd5);
        sendElem("rerun_e1", 8'd3, 8'd4);
        sendElem("rerun_e2", 8'd10, 8'd2);
        checkOutput("rerun_c2", 32'(mac_c), 32'd17);
        waitResult("rerun", 16'd37, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
